// File: rtl/if_program_controller.sv
// Debug sequencer for the fetch stage: loads instruction memory from UART bytes,
// then runs the program freely or one cycle at a time until the HALT word.
module if_program_controller #(
    parameter int NB_MEM_WIDTH = 8,
    parameter int NB_IM_DEPTH  = 8,
    parameter int NB_CYCLES    = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    input  logic                    i_halt,
    output logic                    o_im_enable,
    output logic                    o_write_enable,
    output logic [NB_MEM_WIDTH-1:0] o_write_data,
    output logic [NB_IM_DEPTH-1:0]  o_write_addr,
    output logic                    o_read_enable,
    output logic                    o_pc_enable,
    output logic                    o_pc_reset,
    output logic                    o_step_done,
    output logic                    o_load_done,
    output logic                    o_halted,
    output logic [NB_CYCLES-1:0]    o_cycle_count
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LOAD        = 3'd1;
    localparam logic [2:0] ST_LOAD_FINISH = 3'd2;
    localparam logic [2:0] ST_RUN         = 3'd3;
    localparam logic [2:0] ST_STEP_WAIT   = 3'd4;
    localparam logic [2:0] ST_STEP_EXEC   = 3'd5;
    localparam logic [2:0] ST_HALTED      = 3'd6;

    localparam logic [NB_MEM_WIDTH-1:0] CMD_LOAD = NB_MEM_WIDTH'(8'h4C);
    localparam logic [NB_MEM_WIDTH-1:0] CMD_CONT = NB_MEM_WIDTH'(8'h43);
    localparam logic [NB_MEM_WIDTH-1:0] CMD_STEP = NB_MEM_WIDTH'(8'h53);
    localparam logic [NB_MEM_WIDTH-1:0] CMD_NEXT = NB_MEM_WIDTH'(8'h4E);

    logic [2:0]              r_state;
    logic [NB_IM_DEPTH-1:0]  r_addr;
    logic                    r_word_ff;
    logic [NB_CYCLES-1:0]    r_cycle_count;
    logic                    r_im_enable;
    logic                    r_write_enable;
    logic [NB_MEM_WIDTH-1:0] r_write_data;
    logic [NB_IM_DEPTH-1:0]  r_write_addr;
    logic                    r_read_enable;
    logic                    r_pc_enable;
    logic                    r_pc_reset;
    logic                    r_step_done;
    logic                    r_load_done;
    logic                    r_halted;

    logic [2:0] w_next_state;
    logic       w_load_start;
    logic       w_load_byte;
    logic       w_word_ff;
    logic       w_load_last;

    // Running "every byte of this word so far was 0xFF"; restarts on each word's first byte.
    assign w_word_ff   = (r_addr[1:0] == 2'b00 || r_word_ff) && (i_rx_data == {NB_MEM_WIDTH{1'b1}});
    assign w_load_last = (r_addr[1:0] == 2'b11 && w_word_ff) || (r_addr == {NB_IM_DEPTH{1'b1}});

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        w_next_state = r_state;
        w_load_start = 1'b0;
        w_load_byte  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                    w_next_state = ST_LOAD;
                    w_load_start = 1'b1;
                end else if (i_rx_valid && i_rx_data == CMD_CONT) begin
                    w_next_state = ST_RUN;
                end else if (i_rx_valid && i_rx_data == CMD_STEP) begin
                    w_next_state = ST_STEP_WAIT;
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    w_load_byte = 1'b1;
                    if (w_load_last) w_next_state = ST_LOAD_FINISH;
                end
            end
            ST_LOAD_FINISH: w_next_state = ST_IDLE;
            ST_RUN: begin
                if (i_halt) w_next_state = ST_HALTED;
            end
            ST_STEP_WAIT: begin
                if (i_halt) w_next_state = ST_HALTED;
                else if (i_rx_valid && i_rx_data == CMD_NEXT) w_next_state = ST_STEP_EXEC;
            end
            ST_STEP_EXEC: w_next_state = ST_STEP_WAIT;
            ST_HALTED: begin
                if (i_rx_valid && i_rx_data == CMD_LOAD) begin
                    w_next_state = ST_LOAD;
                    w_load_start = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            // NOTE: all state is updated with non-blocking assignments, so every flop samples pre-edge values.
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_word_ff      <= 1'b0;
            r_cycle_count  <= '0;
            r_im_enable    <= 1'b0;
            r_write_enable <= 1'b0;
            r_write_data   <= '0;
            r_write_addr   <= '0;
            r_read_enable  <= 1'b0;
            r_pc_enable    <= 1'b0;
            r_pc_reset     <= 1'b1;
            r_step_done    <= 1'b0;
            r_load_done    <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_write_enable <= w_load_byte;
            if (w_load_byte) begin
                r_write_data <= i_rx_data;
                r_write_addr <= r_addr;
                r_addr       <= r_addr + NB_IM_DEPTH'(1);
                r_word_ff    <= w_word_ff;
            end
            if (w_load_start) begin
                r_addr        <= '0;
                r_word_ff     <= 1'b0;
                r_cycle_count <= '0;
            end else if (r_pc_enable && r_cycle_count != {NB_CYCLES{1'b1}}) begin
                r_cycle_count <= r_cycle_count + NB_CYCLES'(1);
            end
            r_im_enable   <= 1'b1;
            r_load_done   <= (r_state == ST_LOAD_FINISH);
            r_step_done   <= (r_state == ST_STEP_EXEC);
            r_pc_enable   <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP_EXEC);
            r_pc_reset    <= (w_next_state == ST_IDLE) || (w_next_state == ST_LOAD) ||
                             (w_next_state == ST_LOAD_FINISH);
            r_read_enable <= (w_next_state == ST_RUN) || (w_next_state == ST_STEP_WAIT) ||
                             (w_next_state == ST_STEP_EXEC);
            r_halted      <= (w_next_state == ST_HALTED);
        end
    end

    assign o_im_enable    = r_im_enable;
    assign o_write_enable = r_write_enable;
    assign o_write_data   = r_write_data;
    assign o_write_addr   = r_write_addr;
    assign o_read_enable  = r_read_enable;
    assign o_pc_enable    = r_pc_enable;
    assign o_pc_reset     = r_pc_reset;
    assign o_step_done    = r_step_done;
    assign o_load_done    = r_load_done;
    assign o_halted       = r_halted;
    assign o_cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_if_program_controller.sv
// Randomized bench for if_program_controller: a transaction-level model predicts writes,
// load completion, PC pulses and the cycle count; a narrow-count instance checks saturation.
module tb_if_program_controller;

    localparam int         NB_SAT  = 4;
    localparam int         SAT_MAX = (1 << NB_SAT) - 1;
    localparam logic [7:0] B_L = 8'h4C, B_C = 8'h43, B_S = 8'h53, B_N = 8'h4E;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_valid = 1'b0;
    logic       i_halt = 1'b0;

    logic        o_im_enable, o_write_enable, o_read_enable, o_pc_enable, o_pc_reset;
    logic        o_step_done, o_load_done, o_halted;
    logic [7:0]  o_write_data, o_write_addr;
    logic [31:0] o_cycle_count;

    logic        s_im_enable, s_write_enable, s_read_enable, s_pc_enable, s_pc_reset;
    logic        s_step_done, s_load_done, s_halted;
    logic [7:0]  s_write_data, s_write_addr;
    logic [NB_SAT-1:0] s_cycle_count;

    if_program_controller dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .i_halt(i_halt), .o_im_enable(o_im_enable), .o_write_enable(o_write_enable),
        .o_write_data(o_write_data), .o_write_addr(o_write_addr), .o_read_enable(o_read_enable),
        .o_pc_enable(o_pc_enable), .o_pc_reset(o_pc_reset), .o_step_done(o_step_done),
        .o_load_done(o_load_done), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
    );

    if_program_controller #(.NB_CYCLES(NB_SAT)) dut_sat (
        .i_clock(i_clock), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .i_halt(i_halt), .o_im_enable(s_im_enable), .o_write_enable(s_write_enable),
        .o_write_data(s_write_data), .o_write_addr(s_write_addr), .o_read_enable(s_read_enable),
        .o_pc_enable(s_pc_enable), .o_pc_reset(s_pc_reset), .o_step_done(s_step_done),
        .o_load_done(s_load_done), .o_halted(s_halted), .o_cycle_count(s_cycle_count)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_count = 0;
    int         n_prst_low = 0;
    bit         in_load = 1'b0;
    wr_t        act_w[$];
    wr_t        exp_w[$];
    int         act_done[$];
    logic [7:0] stim[$];

    always @(posedge i_clock) cyc <= cyc + 1;

    always @(negedge i_clock) begin
        wr_t w;
        if (o_write_enable) begin
            w.cyc  = cyc;
            w.addr = int'(o_write_addr);
            w.data = int'(o_write_data);
            act_w.push_back(w);
        end
        if (o_load_done) act_done.push_back(cyc);
        if (in_load && !o_pc_reset) n_prst_low++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge i_clock);
        #1;
        i_rx_valid = 1'b0;
    endtask

    function automatic int sat_count(input int c);
        return (c > SAT_MAX) ? SAT_MAX : c;
    endfunction

    task automatic check_count(input string tag);
        check({tag, " count"}, o_cycle_count, exp_count);
        check({tag, " sat_count"}, s_cycle_count, sat_count(exp_count));
    endtask

    // Sends 'L' then bytes from stim (0xFF once stim runs out) until the load rule says it is over.
    task automatic do_load(input string tag, input int gap_max);
        logic [7:0] img [256];
        logic [7:0] b;
        wr_t        w;
        int         a, k, last_w;
        bit         stop;
        act_w.delete();
        act_done.delete();
        exp_w.delete();
        n_prst_low = 0;
        send_byte(B_L);
        exp_count = 0;
        in_load   = 1'b1;
        check({tag, " halted_drop"}, o_halted, 0);
        a = 0; k = 0; stop = 1'b0; last_w = 0;
        while (!stop) begin
            b = (k < stim.size()) ? stim[k] : 8'hFF;
            k++;
            w.cyc = cyc + 1; w.addr = a; w.data = int'(b);
            exp_w.push_back(w);
            last_w = cyc + 1;
            send_byte(b);
            img[a] = b;
            if (a == 255) stop = 1'b1;
            else if (a % 4 == 3 && img[a-3] == 8'hFF && img[a-2] == 8'hFF &&
                     img[a-1] == 8'hFF && img[a] == 8'hFF) stop = 1'b1;
            else a++;
            if (!stop && gap_max > 0) idle($urandom_range(gap_max, 0));
        end
        idle(3);
        in_load = 1'b0;
        check({tag, " n_writes"}, act_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
            check($sformatf("%s w%0d addr", tag, i), act_w[i].addr, exp_w[i].addr);
            check($sformatf("%s w%0d data", tag, i), act_w[i].data, exp_w[i].data);
            check($sformatf("%s w%0d cyc", tag, i), act_w[i].cyc, exp_w[i].cyc);
        end
        check({tag, " n_done"}, act_done.size(), 1);
        if (act_done.size() > 0) check({tag, " done_cyc"}, act_done[0], last_w + 1);
        check({tag, " pc_reset_low"}, n_prst_low, 0);
        check({tag, " idle_pc_reset"}, o_pc_reset, 1);
        check({tag, " idle_pc_enable"}, o_pc_enable, 0);
        check_count(tag);
    endtask

    task automatic do_run(input string tag, input int n);
        send_byte(B_C);
        check({tag, " pc_enable"}, o_pc_enable, 1);
        check({tag, " pc_reset"}, o_pc_reset, 0);
        check({tag, " read_enable"}, o_read_enable, 1);
        idle(n - 1);
        i_halt = 1'b1;
        idle(1);
        exp_count += n;
        check({tag, " pe_after_halt"}, o_pc_enable, 0);
        check({tag, " halted"}, o_halted, 1);
        check_count(tag);
        idle(2);
        send_byte(B_C);
        send_byte(B_S);
        idle(2);
        check({tag, " frozen_pe"}, o_pc_enable, 0);
        check({tag, " still_halted"}, o_halted, 1);
        check({tag, " halted_pc_reset"}, o_pc_reset, 0);
        check_count({tag, " frozen"});
        i_halt = 1'b0;
    endtask

    task automatic do_step(input string tag, input int n_steps, input int gap);
        send_byte(B_S);
        check({tag, " wait_pe"}, o_pc_enable, 0);
        check({tag, " wait_pc_reset"}, o_pc_reset, 0);
        check({tag, " wait_read"}, o_read_enable, 1);
        for (int i = 0; i < n_steps; i++) begin
            idle(gap);
            send_byte(B_N);
            check($sformatf("%s s%0d pe", tag, i), o_pc_enable, 1);
            check($sformatf("%s s%0d early_done", tag, i), o_step_done, 0);
            idle(1);
            check($sformatf("%s s%0d pe_drop", tag, i), o_pc_enable, 0);
            check($sformatf("%s s%0d step_done", tag, i), o_step_done, 1);
            exp_count++;
            idle(1);
            check($sformatf("%s s%0d done_drop", tag, i), o_step_done, 0);
            check($sformatf("%s s%0d halted", tag, i), o_halted, 0);
        end
        check_count(tag);
        send_byte(B_C);
        check({tag, " ignored_C"}, o_pc_enable, 0);
        i_halt = 1'b1;
        send_byte(B_N);
        check({tag, " halt_N_pe"}, o_pc_enable, 0);
        check({tag, " halt_N_halted"}, o_halted, 1);
        idle(2);
        check({tag, " halt_N_no_done"}, o_step_done, 0);
        check_count({tag, " halt_N"});
        i_halt = 1'b0;
    endtask

    task automatic random_stim(input int len);
        stim.delete();
        for (int i = 0; i < len; i++)
            stim.push_back(($urandom_range(9, 0) < 3) ? 8'hFF : 8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge i_clock);
        #1;
        idle(3);
        check("rst pc_reset", o_pc_reset, 1);
        check("rst im_enable", o_im_enable, 0);
        check("rst write_enable", o_write_enable, 0);
        check("rst write_addr", o_write_addr, 0);
        check("rst write_data", o_write_data, 0);
        check("rst read_enable", o_read_enable, 0);
        check("rst pc_enable", o_pc_enable, 0);
        check("rst step_done", o_step_done, 0);
        check("rst load_done", o_load_done, 0);
        check("rst halted", o_halted, 0);
        check("rst count", o_cycle_count, 0);
        i_reset = 1'b1;
        idle(2);
        check("idle pc_reset", o_pc_reset, 1);
        check("idle im_enable", o_im_enable, 1);

        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load("load_basic", 0);

        do_run("run10", 10);

        stim = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load("load_unaligned", 1);

        do_step("step3", 3, 2);

        stim.delete();
        repeat (256) stim.push_back(8'h01);
        do_load("load_full", 0);
        act_w.delete();
        send_byte(8'h01);
        idle(2);
        check("full byte257 writes", act_w.size(), 0);

        send_byte(B_L);
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        i_reset = 1'b0;
        idle(1);
        i_reset = 1'b1;
        exp_count = 0;
        check("midrst write_enable", o_write_enable, 0);
        check("midrst write_addr", o_write_addr, 0);
        check("midrst pc_reset", o_pc_reset, 1);
        check("midrst pc_enable", o_pc_enable, 0);
        check_count("midrst");
        idle(1);
        random_stim(10);
        do_load("load_after_rst", 2);

        for (int it = 0; it < 8; it++) begin
            random_stim($urandom_range(40, 1));
            do_load($sformatf("rnd%0d load", it), 2);
            if ($urandom_range(1, 0) == 1)
                do_run($sformatf("rnd%0d run", it), $urandom_range(20, 1));
            else
                do_step($sformatf("rnd%0d step", it), $urandom_range(4, 1), $urandom_range(3, 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_program_controller.md
Name: if_program_controller

Overview:
- Debug-side sequencer for the instruction-fetch stage.
- Receives a byte stream from the UART receiver.
- Loads program bytes into instruction memory through its byte-wide debug write port.
- Then runs the program continuously or single-stepped, by driving the PC enable/reset and memory enable/read controls.
- Sits between the UART RX and the fetch stage; also exports a step strobe and cycle count to the debug dump logic.

Parameters:
- NB_MEM_WIDTH, 8, instruction-memory write-port data width (bytes from UART).
- NB_IM_DEPTH, 8, instruction-memory address width (256 bytes).
- NB_CYCLES, 32, width of executed-cycle counter.

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_rx_data  in  NB_MEM_WIDTH  byte from UART receiver.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle.
- i_halt  in  1  pipeline has fetched/retired the HALT word; level.
- o_im_enable  out  1  instruction-memory enable.
- o_write_enable  out  1  instruction-memory byte write strobe.
- o_write_data  out  NB_MEM_WIDTH  byte to write.
- o_write_addr  out  NB_IM_DEPTH  byte address to write.
- o_read_enable  out  1  instruction-memory read enable.
- o_pc_enable  out  1  PC register update enable.
- o_pc_reset  out  1  PC clear, active-high, held while not executing.
- o_step_done  out  1  one-cycle pulse after each single-step cycle.
- o_load_done  out  1  one-cycle pulse when a load completes.
- o_halted  out  1  level; program reached HALT.
- o_cycle_count  out  NB_CYCLES  number of cycles with o_pc_enable=1 since last load command.

Behaviour:
- Commands are bytes, recognised only in the states listed below; all unlisted bytes are ignored.
  - 'L' = 0x4C, 'C' = 0x43, 'S' = 0x53, 'N' = 0x4E.
- Reset (i_reset=0 at a clock edge):
  - state=IDLE, write address counter=0, o_cycle_count=0.
  - All outputs 0 except o_pc_reset=1.
  - Reset wins over every other event, including mid-load and mid-step. Memory contents are not cleared.
- IDLE:
  - o_pc_reset=1; o_pc_enable=0; o_im_enable=1.
  - 'L' -> LOAD: address counter=0, o_cycle_count=0, FF-run counter=0.
  - 'C' -> RUN. 'S' -> STEP_WAIT.
- LOAD:
  - o_pc_reset=1; o_im_enable=1.
  - Each i_rx_valid byte B at address counter A produces, on the next cycle, o_write_enable=1 for exactly one cycle with o_write_data=B and o_write_addr=A. Then A increments (8-bit).
  - A word ends when A[1:0]==3. If all 4 bytes of that word were 0xFF (HALT word), finish the load.
  - The load also finishes after writing A=255 (memory full; no wrap-around).
  - Finish: o_load_done pulses in the cycle after the final write strobe; state -> IDLE.
- RUN:
  - o_pc_reset=0; o_pc_enable=1; o_read_enable=1; o_im_enable=1.
  - o_cycle_count +1 per cycle with o_pc_enable=1.
  - i_halt=1 -> HALTED, with o_pc_enable=0 in the next cycle. UART bytes are ignored.
- STEP_WAIT:
  - o_pc_reset=0; o_pc_enable=0; o_read_enable=1.
  - 'N' -> STEP_EXEC.
  - i_halt=1 -> HALTED; i_halt takes priority over a simultaneous 'N'.
- STEP_EXEC:
  - Lasts exactly one cycle with o_pc_enable=1; count +1.
  - Next state STEP_WAIT, with o_step_done=1 during that first STEP_WAIT cycle.
- HALTED:
  - o_halted=1; o_pc_enable=0; o_pc_reset=0; o_cycle_count frozen.
  - 'L' -> LOAD (o_halted drops in the same edge). All other bytes are ignored.
- Output registration and width rules:
  - All outputs are registered; no combinational path from i_rx_* or i_halt to any output.
  - o_cycle_count saturates at all-ones.

Test Plan:
- Load: reset, send 0x4C, 0x11, 0x22, 0x33, 0x44, 0xFF×4.
  - 8 write strobes at addr 0..7 with data 11, 22, 33, 44, FF, FF, FF, FF.
  - o_load_done one cycle after the addr-7 write; state IDLE; o_pc_reset stays 1 throughout.
- Unaligned FF: load 0x4C, 0x00, 0xFF×4, then 0xFF×3.
  - The FF run straddling a word boundary does not stop the load.
  - The load stops after addr 7 (word 4..7 is all FF); total 8 writes.
- Full: send 0x4C followed by 256 bytes of 0x01.
  - 256 strobes, addr 0..255. o_load_done after addr 255.
  - A 257th byte produces no write.
- Run: after a load, send 0x43; assert i_halt 10 cycles after o_pc_enable rises.
  - o_pc_reset=0; o_cycle_count=10 and frozen; o_halted=1; o_pc_enable=0 next cycle.
- Step: send 0x53, then 0x4E three times spaced 5 cycles apart.
  - Exactly 3 single-cycle o_pc_enable pulses, each followed by an o_step_done pulse; o_cycle_count=3.
  - Then i_halt together with 0x4E: no pulse, o_halted=1.
- Reset mid-load: i_reset=0 for one cycle after 3 loaded bytes.
  - Next cycle: o_write_enable=0, o_write_addr=0, IDLE.
  - A fresh load restarts writing at addr 0.
